// File: rtl/hls_chn_pkg.sv
// rtl/hls_chn_pkg.sv - shared parameters and helpers for the multi-channel output wait controller
package hls_chn_pkg;

  localparam int DEF_NUM_CHN = 2;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_DEPTH   = 2;
  localparam int DEF_CNT_W   = 16;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int cnt_depth_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic bit depth_ok(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

  function automatic bit num_chn_ok(input int num_chn);
    return (num_chn >= 1) && (num_chn <= 8);
  endfunction

endpackage

// File: rtl/hls_chn_o_rsci_wait_ctrl_nch_if.sv
// rtl/hls_chn_o_rsci_wait_ctrl_nch_if.sv - core-side and downstream handshake bundle
interface hls_chn_o_rsci_wait_ctrl_nch_if #(
  parameter int NUM_CHN = 2,
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 16
);
  logic                       core_wen;
  logic                       core_wten;
  logic [NUM_CHN-1:0]         chn_o_rsci_oswt;
  logic [NUM_CHN-1:0]         chn_o_rsci_iswt0;
  logic [NUM_CHN-1:0]         chn_o_rsci_ld_core_psct;
  logic [NUM_CHN*DATA_W-1:0]  chn_o_core_data;
  logic [NUM_CHN-1:0]         chn_o_rsci_biwt;
  logic [NUM_CHN-1:0]         chn_o_rsci_bdwt;
  logic [NUM_CHN-1:0]         chn_o_rsci_ld_core_sct;
  logic                       core_stall_req;
  logic [NUM_CHN-1:0]         chn_o_vld;
  logic [NUM_CHN-1:0]         chn_o_rdy;
  logic [NUM_CHN*DATA_W-1:0]  chn_o_pd;
  logic                       stall_cnt_clr;
  logic [NUM_CHN*CNT_W-1:0]   stall_cnt;

  modport master (
    output core_wen, core_wten, chn_o_rsci_oswt, chn_o_rsci_iswt0, chn_o_rsci_ld_core_psct,
           chn_o_core_data, chn_o_rdy, stall_cnt_clr,
    input  chn_o_rsci_biwt, chn_o_rsci_bdwt, chn_o_rsci_ld_core_sct, core_stall_req,
           chn_o_vld, chn_o_pd, stall_cnt
  );

  modport slave (
    input  core_wen, core_wten, chn_o_rsci_oswt, chn_o_rsci_iswt0, chn_o_rsci_ld_core_psct,
           chn_o_core_data, chn_o_rdy, stall_cnt_clr,
    output chn_o_rsci_biwt, chn_o_rsci_bdwt, chn_o_rsci_ld_core_sct, core_stall_req,
           chn_o_vld, chn_o_pd, stall_cnt
  );
endinterface

// File: rtl/hls_chn_o_skid_fifo.sv
// rtl/hls_chn_o_skid_fifo.sv - per-channel skid FIFO, registered head, no full or empty bypass
module hls_chn_o_skid_fifo
  import hls_chn_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              nvdla_core_clk,
  input  logic              nvdla_core_rstn,
  input  logic              push_i,
  input  logic [DATA_W-1:0] din_i,
  output logic              full_o,
  input  logic              pop_i,
  output logic [DATA_W-1:0] dout_o,
  output logic              vld_o
);
  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CW    = cnt_depth_w(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign vld_o   = (count_q != '0);
  assign dout_o  = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & vld_o;

  // DEPTH is a power of two, so pointer overflow is the modulo wrap
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (!do_push && do_pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) mem_q[wr_ptr_q] <= din_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/hls_chn_o_rsci_wait_ctrl_nch.sv
// rtl/hls_chn_o_rsci_wait_ctrl_nch.sv - multi-channel output wait control with skid FIFOs and stall counters
module hls_chn_o_rsci_wait_ctrl_nch
  import hls_chn_pkg::*;
#(
  parameter int NUM_CHN = DEF_NUM_CHN,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int CNT_W   = DEF_CNT_W
) (
  input logic                         nvdla_core_clk,
  input logic                         nvdla_core_rstn,
  hls_chn_o_rsci_wait_ctrl_nch_if.slave bus
);
  if (!num_chn_ok(NUM_CHN)) begin : g_bad_num_chn
    $error("NUM_CHN must be in 1..8");
  end
  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("DEPTH must be a power of two and at least 2");
  end

  logic [NUM_CHN-1:0]        icwt_q, icwt_d;
  logic [NUM_CHN-1:0]        ogwt, full, biwt, stall;
  logic [NUM_CHN-1:0]        vld;
  logic [NUM_CHN*DATA_W-1:0] pd;
  logic [NUM_CHN*CNT_W-1:0]  cnt;

  // biwt sees only registered FIFO state, keeping rdy out of the core-side path
  assign ogwt   = (bus.chn_o_rsci_iswt0 & ~{NUM_CHN{bus.core_wten}}) | icwt_q;
  assign biwt   = ogwt & ~full;
  assign stall  = ogwt & full;
  assign icwt_d = ogwt & ~biwt;

  assign bus.chn_o_rsci_biwt        = biwt;
  assign bus.chn_o_rsci_bdwt        = bus.chn_o_rsci_oswt & {NUM_CHN{bus.core_wen}};
  assign bus.chn_o_rsci_ld_core_sct = bus.chn_o_rsci_ld_core_psct & biwt;
  assign bus.core_stall_req         = |stall;
  assign bus.chn_o_vld              = vld;
  assign bus.chn_o_pd               = pd;
  assign bus.stall_cnt              = cnt;

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) icwt_q <= '0;
    else                  icwt_q <= icwt_d;
  end

  for (genvar g = 0; g < NUM_CHN; g++) begin : g_chn
    logic [CNT_W-1:0] cnt_q, cnt_d;

    hls_chn_o_skid_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .nvdla_core_clk  (nvdla_core_clk),
      .nvdla_core_rstn (nvdla_core_rstn),
      .push_i          (biwt[g]),
      .din_i           (bus.chn_o_core_data[g*DATA_W +: DATA_W]),
      .full_o          (full[g]),
      .pop_i           (bus.chn_o_rdy[g]),
      .dout_o          (pd[g*DATA_W +: DATA_W]),
      .vld_o           (vld[g])
    );

    // clear wins over increment; the count sticks at all-ones
    always_comb begin
      cnt_d = cnt_q;
      if (bus.stall_cnt_clr)                         cnt_d = '0;
      else if (stall[g] && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) cnt_q <= '0;
      else                  cnt_q <= cnt_d;
    end

    assign cnt[g*CNT_W +: CNT_W] = cnt_q;
  end
endmodule
